// File: rtl/fetch_align_buffer_pkg.sv
// Shared types and constants for the parcel-aligning fetch buffer.
package fetch_align_buffer_pkg;

  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;
  localparam int PARCEL_W = 16;

  typedef enum logic {S_IDLE, S_WAIT} fab_state_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;
    logic            uncached;
  } icache_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
  } icache_res_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] blk;
  } gbuff_res_t;

  function automatic logic [PARCEL_W-1:0] get_parcel(input logic [BLK_SIZE-1:0] line,
                                                     input logic [2:0] p);
    return line[{p, 4'b0000} +: PARCEL_W];
  endfunction

endpackage

// File: rtl/fetch_align_buffer_bank.sv
// Direct-mapped parcel bank with per-entry tag/valid and two lookup ports.
module align_bank #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 25,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DEPTH-1:0]  i_clr_mask,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx_a,
  input  logic [TAG_W-1:0]  i_rd_tag_a,
  input  logic [IDX_W-1:0]  i_rd_idx_b,
  input  logic [TAG_W-1:0]  i_rd_tag_b,
  output logic              o_hit_a,
  output logic              o_hit_b,
  output logic [DATA_W-1:0] o_data_a,
  output logic [DATA_W-1:0] o_data_b
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // Clears land first so a fill to the same entry in the same cycle survives.
  always_comb begin
    w_valid_nxt = r_valid & ~i_clr_mask;
    if (i_wr_en) w_valid_nxt[i_wr_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_valid <= '0;
    else       r_valid <= w_valid_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit_a  = r_valid[i_rd_idx_a] && (r_tag[i_rd_idx_a] == i_rd_tag_a);
  assign o_hit_b  = r_valid[i_rd_idx_b] && (r_tag[i_rd_idx_b] == i_rd_tag_b);
  assign o_data_a = r_data[i_rd_idx_a];
  assign o_data_b = r_data[i_rd_idx_b];

endmodule

// File: rtl/fetch_align_buffer.sv
// Returns a 32-bit parcel-aligned fetch window, filling missing lines from the icache one at a time.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  icache_req_t buff_req_i,
  output gbuff_res_t  buff_res_o,
  output logic        buffer_miss_o,
  input  icache_res_t lowX_res_i,
  output icache_req_t lowX_req_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LINE_W = XLEN - 4;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int HALF_W = BLK_SIZE / 2;

  fab_state_t        r_state;
  logic [XLEN-1:0]   r_addr;
  logic              r_unc;
  logic              r_discard;
  logic [LINE_W-1:0] r_prev_a;
  logic [DEPTH-1:0]  r_unc_mask;

  logic [LINE_W-1:0]   w_line_a, w_line_b, w_miss_line;
  logic [IDX_W-1:0]    w_idx_a, w_idx_b, w_wr_idx;
  logic [2:0]          w_p;
  logic                w_moved, w_wr_en, w_a_ok, w_b_ok, w_b_need, w_hit;
  logic [DEPTH-1:0]    w_clr_mask, w_unc_mask_nxt;
  logic                w_hit_ea, w_hit_eb, w_hit_oa, w_hit_ob;
  logic [HALF_W-1:0]   w_even_a, w_even_b, w_odd_a, w_odd_b;
  logic [HALF_W-1:0]   w_even_wr, w_odd_wr;
  logic [BLK_SIZE-1:0] w_line_data_a;
  logic [15:0]         w_low, w_high;
  logic                w_unused;

  assign w_line_a = buff_req_i.addr[XLEN-1:4];
  assign w_line_b = w_line_a + LINE_W'(1);
  assign w_p      = buff_req_i.addr[3:1];
  assign w_idx_a  = w_line_a[IDX_W-1:0];
  assign w_idx_b  = w_line_b[IDX_W-1:0];
  assign w_wr_idx = r_addr[4 +: IDX_W];

  // Uncached lines are dropped as soon as the request moves to another line A.
  assign w_moved    = buff_req_i.valid && (w_line_a != r_prev_a);
  assign w_clr_mask = flush_i ? '1 : (w_moved ? r_unc_mask : '0);
  assign w_wr_en    = (r_state == S_WAIT) && lowX_res_i.valid && !r_discard && !flush_i;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_even_wr[16*k +: 16]          = lowX_res_i.blk[32*k +: 16];
      w_odd_wr[16*k +: 16]           = lowX_res_i.blk[32*k+16 +: 16];
      w_line_data_a[32*k +: 16]      = w_even_a[16*k +: 16];
      w_line_data_a[32*k+16 +: 16]   = w_odd_a[16*k +: 16];
    end
  end

  align_bank #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(HALF_W)) u_even (
    .clk_i(clk_i), .rst_i(rst_i), .i_clr_mask(w_clr_mask),
    .i_wr_en(w_wr_en), .i_wr_idx(w_wr_idx), .i_wr_tag(r_addr[XLEN-1 -: TAG_W]), .i_wr_data(w_even_wr),
    .i_rd_idx_a(w_idx_a), .i_rd_tag_a(w_line_a[LINE_W-1:IDX_W]),
    .i_rd_idx_b(w_idx_b), .i_rd_tag_b(w_line_b[LINE_W-1:IDX_W]),
    .o_hit_a(w_hit_ea), .o_hit_b(w_hit_eb), .o_data_a(w_even_a), .o_data_b(w_even_b)
  );

  align_bank #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(HALF_W)) u_odd (
    .clk_i(clk_i), .rst_i(rst_i), .i_clr_mask(w_clr_mask),
    .i_wr_en(w_wr_en), .i_wr_idx(w_wr_idx), .i_wr_tag(r_addr[XLEN-1 -: TAG_W]), .i_wr_data(w_odd_wr),
    .i_rd_idx_a(w_idx_a), .i_rd_tag_a(w_line_a[LINE_W-1:IDX_W]),
    .i_rd_idx_b(w_idx_b), .i_rd_tag_b(w_line_b[LINE_W-1:IDX_W]),
    .o_hit_a(w_hit_oa), .o_hit_b(w_hit_ob), .o_data_a(w_odd_a), .o_data_b(w_odd_b)
  );

  assign w_a_ok   = w_hit_ea && w_hit_oa && !w_clr_mask[w_idx_a];
  assign w_b_ok   = w_hit_eb && w_hit_ob && !w_clr_mask[w_idx_b];
  assign w_low    = get_parcel(w_line_data_a, w_p);
  assign w_b_need = (w_p == 3'd7) && (w_low[1:0] == 2'b11);
  assign w_high   = (w_p != 3'd7) ? get_parcel(w_line_data_a, w_p + 3'd1)
                                  : (w_b_need ? w_even_b[15:0] : 16'h0000);
  assign w_hit    = buff_req_i.valid && !flush_i && w_a_ok && (w_b_ok || !w_b_need);
  assign w_miss_line = w_a_ok ? w_line_b : w_line_a;

  assign buff_res_o.valid = w_hit;
  assign buff_res_o.ready = 1'b1;
  assign buff_res_o.blk   = {w_high, w_low};
  assign buffer_miss_o    = buff_req_i.valid && !w_hit;

  assign lowX_req_o.valid    = (r_state == S_WAIT);
  assign lowX_req_o.ready    = 1'b1;
  assign lowX_req_o.addr     = r_addr;
  assign lowX_req_o.uncached = r_unc;

  // A flush while waiting still consumes the response but marks it for discard.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_unc     <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (buffer_miss_o && !flush_i) begin
            r_addr    <= {w_miss_line, 4'b0000};
            r_unc     <= buff_req_i.uncached;
            r_discard <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lowX_res_i.valid) begin
            r_discard <= 1'b0;
            r_state   <= S_IDLE;
          end else if (flush_i) begin
            r_discard <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_unc_mask_nxt = w_moved ? '0 : r_unc_mask;
    if (w_wr_en && r_unc) w_unc_mask_nxt[w_wr_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev_a   <= '0;
      r_unc_mask <= '0;
    end else begin
      if (buff_req_i.valid) r_prev_a <= w_line_a;
      r_unc_mask <= flush_i ? '0 : w_unc_mask_nxt;
    end
  end

  assign w_unused = ^{buff_req_i.ready, buff_req_i.addr[0], lowX_res_i.ready, w_odd_b, w_even_b[HALF_W-1:16]};

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed self-checking bench for fetch_align_buffer: fills, alignment, straddle, flush, uncached, reset.
module tb_fetch_align_buffer;
  import fetch_align_buffer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  icache_req_t buff_req_i;
  gbuff_res_t  buff_res_o;
  logic        buffer_miss_o;
  icache_res_t lowX_res_i;
  icache_req_t lowX_req_o;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] LINE0_C = 128'h4501_5555_4444_3333_2222_1111_0013_0537;
  localparam logic [127:0] LINE0_S = 128'h0297_5555_4444_3333_2222_1111_0013_0537;
  localparam logic [127:0] LINE1   = 128'h1707_1606_1505_1404_1303_1202_1101_0093;
  localparam logic [127:0] LINE2   = 128'h2f2e_2d2c_2b2a_2928_2726_2524_2322_2120;
  localparam logic [127:0] LINE3   = 128'h3f3e_3d3c_3b3a_3938_3736_3534_3332_3130;
  localparam logic [127:0] LINE4   = 128'h4f4e_4d4c_4b4a_4948_4746_4544_4342_4140;
  localparam logic [127:0] LINE5   = 128'h5f5e_5d5c_5b5a_5958_5756_5554_5352_5150;

  always #5 clk_i = ~clk_i;

  fetch_align_buffer #(.DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .buff_req_i(buff_req_i), .buff_res_o(buff_res_o), .buffer_miss_o(buffer_miss_o),
    .lowX_res_i(lowX_res_i), .lowX_req_o(lowX_req_o)
  );

  task automatic set_req(input logic v, input logic [31:0] a, input logic u);
    buff_req_i.valid    = v;
    buff_req_i.ready    = 1'b1;
    buff_req_i.addr     = a;
    buff_req_i.uncached = u;
  endtask

  task automatic set_res(input logic v, input logic [127:0] b);
    lowX_res_i.valid = v;
    lowX_res_i.ready = 1'b1;
    lowX_res_i.blk   = b;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    set_req(1'b1, 32'h8000_0000, 1'b0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b0 || buffer_miss_o !== 1'b1 || lowX_req_o.valid !== 1'b0 || lowX_req_o.addr !== 32'h0)
      $display("[TB] FAIL reset_state: res_v=%b miss=%b req_v=%b req_addr=%h expected 0 1 0 00000000",
               buff_res_o.valid, buffer_miss_o, lowX_req_o.valid, lowX_req_o.addr);
    else n_pass++;
    set_req(1'b0, 32'h8000_0000, 1'b0);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b0 || buff_res_o.valid !== 1'b0)
      $display("[TB] FAIL reset_idle_req: miss=%b res_v=%b expected 0 0", buffer_miss_o, buff_res_o.valid);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_cold_miss();
    @(negedge clk_i);
    set_req(1'b1, 32'h8000_0000, 1'b0);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1 || buff_res_o.valid !== 1'b0)
      $display("[TB] FAIL cold_miss: miss=%b res_v=%b expected 1 0", buffer_miss_o, buff_res_o.valid);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1 || lowX_req_o.addr !== 32'h8000_0000 || lowX_req_o.uncached !== 1'b0)
      $display("[TB] FAIL cold_request: v=%b addr=%h unc=%b expected 1 80000000 0",
               lowX_req_o.valid, lowX_req_o.addr, lowX_req_o.uncached);
    else n_pass++;
    set_res(1'b1, LINE0_C);
    @(negedge clk_i);
    set_res(1'b0, '0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b1 || buff_res_o.blk !== 32'h0013_0537 || buffer_miss_o !== 1'b0)
      $display("[TB] FAIL cold_fill: v=%b blk=%h miss=%b expected 1 00130537 0",
               buff_res_o.valid, buff_res_o.blk, buffer_miss_o);
    else n_pass++;
  endtask

  task automatic test_odd_hit();
    @(negedge clk_i);
    set_req(1'b1, 32'h8000_0002, 1'b0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b1 || buff_res_o.blk !== 32'h1111_0013)
      $display("[TB] FAIL odd_hit: v=%b blk=%h expected 1 11110013", buff_res_o.valid, buff_res_o.blk);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b0)
      $display("[TB] FAIL odd_hit_no_fetch: req_v=%b expected 0", lowX_req_o.valid);
    else n_pass++;
  endtask

  task automatic test_compressed_p7();
    @(negedge clk_i);
    set_req(1'b1, 32'h8000_000E, 1'b0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b1 || buff_res_o.blk !== 32'h0000_4501 || buffer_miss_o !== 1'b0)
      $display("[TB] FAIL compressed_p7: v=%b blk=%h miss=%b expected 1 00004501 0",
               buff_res_o.valid, buff_res_o.blk, buffer_miss_o);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b0)
      $display("[TB] FAIL compressed_no_fetch: req_v=%b expected 0", lowX_req_o.valid);
    else n_pass++;
  endtask

  task automatic test_straddle();
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b0)
      $display("[TB] FAIL flush_forces_invalid: res_v=%b expected 0", buff_res_o.valid);
    else n_pass++;
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1)
      $display("[TB] FAIL flush_cleared: miss=%b expected 1", buffer_miss_o);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1 || lowX_req_o.addr !== 32'h8000_0000)
      $display("[TB] FAIL straddle_req_a: v=%b addr=%h expected 1 80000000", lowX_req_o.valid, lowX_req_o.addr);
    else n_pass++;
    set_res(1'b1, LINE0_S);
    @(negedge clk_i);
    set_res(1'b0, '0);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1 || buff_res_o.valid !== 1'b0)
      $display("[TB] FAIL straddle_needs_b: miss=%b res_v=%b expected 1 0", buffer_miss_o, buff_res_o.valid);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1 || lowX_req_o.addr !== 32'h8000_0010)
      $display("[TB] FAIL straddle_req_b: v=%b addr=%h expected 1 80000010", lowX_req_o.valid, lowX_req_o.addr);
    else n_pass++;
    set_res(1'b1, LINE1);
    @(negedge clk_i);
    set_res(1'b0, '0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b1 || buff_res_o.blk !== 32'h0093_0297)
      $display("[TB] FAIL straddle_window: v=%b blk=%h expected 1 00930297", buff_res_o.valid, buff_res_o.blk);
    else n_pass++;
  endtask

  task automatic test_flush_wait();
    @(negedge clk_i);
    set_req(1'b1, 32'h8000_0040, 1'b0);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1)
      $display("[TB] FAIL flushwait_miss: miss=%b expected 1", buffer_miss_o);
    else n_pass++;
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1)
      $display("[TB] FAIL flushwait_pending: req_v=%b expected 1", lowX_req_o.valid);
    else n_pass++;
    @(negedge clk_i);
    flush_i = 1'b0;
    set_res(1'b1, LINE2);
    #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1)
      $display("[TB] FAIL flushwait_still_waiting: req_v=%b expected 1", lowX_req_o.valid);
    else n_pass++;
    @(negedge clk_i);
    set_res(1'b0, '0);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1 || buff_res_o.valid !== 1'b0 || lowX_req_o.valid !== 1'b0)
      $display("[TB] FAIL flushwait_discarded: miss=%b res_v=%b req_v=%b expected 1 0 0",
               buffer_miss_o, buff_res_o.valid, lowX_req_o.valid);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1 || lowX_req_o.addr !== 32'h8000_0040)
      $display("[TB] FAIL flushwait_rerequest: v=%b addr=%h expected 1 80000040", lowX_req_o.valid, lowX_req_o.addr);
    else n_pass++;
    set_res(1'b1, LINE2);
    @(negedge clk_i);
    set_res(1'b0, '0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b1 || buff_res_o.blk !== 32'h2322_2120)
      $display("[TB] FAIL flushwait_refill: v=%b blk=%h expected 1 23222120", buff_res_o.valid, buff_res_o.blk);
    else n_pass++;
  endtask

  task automatic test_uncached();
    @(negedge clk_i);
    set_req(1'b1, 32'h1000_0000, 1'b1);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1)
      $display("[TB] FAIL unc_miss: miss=%b expected 1", buffer_miss_o);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1 || lowX_req_o.addr !== 32'h1000_0000 || lowX_req_o.uncached !== 1'b1)
      $display("[TB] FAIL unc_request: v=%b addr=%h unc=%b expected 1 10000000 1",
               lowX_req_o.valid, lowX_req_o.addr, lowX_req_o.uncached);
    else n_pass++;
    set_res(1'b1, LINE3);
    @(negedge clk_i);
    set_res(1'b0, '0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b1 || buff_res_o.blk !== 32'h3332_3130)
      $display("[TB] FAIL unc_served: v=%b blk=%h expected 1 33323130", buff_res_o.valid, buff_res_o.blk);
    else n_pass++;
    @(negedge clk_i);
    set_req(1'b1, 32'h1000_0010, 1'b1);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1)
      $display("[TB] FAIL unc_move_miss: miss=%b expected 1", buffer_miss_o);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.addr !== 32'h1000_0010)
      $display("[TB] FAIL unc_move_req: addr=%h expected 10000010", lowX_req_o.addr);
    else n_pass++;
    set_res(1'b1, LINE4);
    @(negedge clk_i);
    set_res(1'b0, '0);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b1 || buff_res_o.blk !== 32'h4342_4140)
      $display("[TB] FAIL unc_move_served: v=%b blk=%h expected 1 43424140", buff_res_o.valid, buff_res_o.blk);
    else n_pass++;
    @(negedge clk_i);
    set_req(1'b1, 32'h1000_0000, 1'b1);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1 || buff_res_o.valid !== 1'b0)
      $display("[TB] FAIL unc_not_reused: miss=%b res_v=%b expected 1 0", buffer_miss_o, buff_res_o.valid);
    else n_pass++;
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1 || lowX_req_o.addr !== 32'h1000_0000 || lowX_req_o.uncached !== 1'b1)
      $display("[TB] FAIL unc_rerequest: v=%b addr=%h unc=%b expected 1 10000000 1",
               lowX_req_o.valid, lowX_req_o.addr, lowX_req_o.uncached);
    else n_pass++;
    set_res(1'b1, LINE3);
    @(negedge clk_i);
    set_res(1'b0, '0);
    set_req(1'b0, 32'h1000_0000, 1'b1);
    #1;
    n_checks++;
    if (buff_res_o.valid !== 1'b0 || buffer_miss_o !== 1'b0)
      $display("[TB] FAIL idle_req_quiet: res_v=%b miss=%b expected 0 0", buff_res_o.valid, buffer_miss_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk_i);
    set_req(1'b1, 32'h8000_0080, 1'b0);
    @(negedge clk_i); #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b1 || lowX_req_o.addr !== 32'h8000_0080)
      $display("[TB] FAIL rstwait_pending: v=%b addr=%h expected 1 80000080", lowX_req_o.valid, lowX_req_o.addr);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (lowX_req_o.valid !== 1'b0 || lowX_req_o.addr !== 32'h0)
      $display("[TB] FAIL rstwait_abandon: v=%b addr=%h expected 0 00000000", lowX_req_o.valid, lowX_req_o.addr);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    set_req(1'b0, 32'h8000_0080, 1'b0);
    set_res(1'b1, LINE5);
    @(negedge clk_i);
    set_res(1'b0, '0);
    set_req(1'b1, 32'h8000_0080, 1'b0);
    #1;
    n_checks++;
    if (buffer_miss_o !== 1'b1 || buff_res_o.valid !== 1'b0 || lowX_req_o.valid !== 1'b0)
      $display("[TB] FAIL late_response_ignored: miss=%b res_v=%b req_v=%b expected 1 0 0",
               buffer_miss_o, buff_res_o.valid, lowX_req_o.valid);
    else n_pass++;
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    set_req(1'b0, 32'h0, 1'b0);
    set_res(1'b0, '0);
    test_reset();
    test_cold_miss();
    test_odd_hit();
    test_compressed_p7();
    test_straddle();
    test_flush_wait();
    test_uncached();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parcel-aligning fetch buffer between the fetch-stage PC and the instruction cache.
- Returns a 32-bit fetch window for any 2-byte-aligned PC, including windows that straddle a cache line.
- Stores whole lines in two parcel banks and requests missing lines from the icache one at a time.
- Output feeds the compressed decoder.

Parameters:
- XLEN, 32, address/instruction width.
- BLK_SIZE, 128, cache line width in bits (8 parcels of 16 bits).
- DEPTH, 8, direct-mapped line entries (power of two).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  invalidate all entries.
- buff_req_i  in  struct  {valid 1, ready 1, addr XLEN, uncached 1}: fetch request from PC.
- buff_res_o  out  struct  {valid 1, ready 1, blk 32}: aligned window; blk[15:0] is the parcel at addr.
- buffer_miss_o  out  1  request valid and window not available.
- lowX_res_i  in  struct  {valid 1, ready 1, blk BLK_SIZE}: line from icache.
- lowX_req_o  out  struct  {valid 1, ready 1, addr XLEN, uncached 1}: line request to icache.

Behaviour:
- Line A = addr[XLEN-1:4]. Parcel offset p = addr[3:1]. Line B = A+1, wrapping at the top of the address space.
- Entry index = line[log2(DEPTH)-1:0]; tag = remaining upper bits. Each entry holds a valid bit, tag, even bank (parcels 0,2,4,6) and odd bank (parcels 1,3,5,7).
- Low parcel comes from A at offset p.
- High parcel:
  - p<7: from A at offset p+1.
  - p=7: parcel 0 of B.
- B is needed only when p=7 and low parcel[1:0]==2'b11 (32-bit instruction). A compressed parcel at p=7 never requires B. In that case blk[31:16] is don't-care; drive zero.
- Hit = req.valid & A present & (B present or B not needed). Hit is combinational, same cycle: buff_res_o.valid=1, blk driven.
- buffer_miss_o = req.valid & !hit. buff_res_o.ready=1 always. buff_res_o.valid=0 whenever req.valid=0.
- FSM has two states, IDLE and WAIT:
  - IDLE, miss: latch the missing line address (A if A absent, else B) as a line-aligned address (low 4 bits zero) plus uncached; go to WAIT.
  - WAIT: lowX_req_o.valid=1 with the latched addr/uncached; lowX_req_o.ready=1.
  - WAIT, on lowX_res_i.valid: write the line into its entry (tag, both banks, valid=1); go to IDLE. Exactly one request is in flight.
- Miss latencies:
  - Single-line miss: miss cycle → request from next cycle → response cycle writes → hit the cycle after the response.
  - Both lines missing: two sequential fetches, A then B.
- Uncached request: the line is written and used for that window. Its valid bit clears when the request moves to a different line A, so it is never reused later.
- flush_i:
  - Clears all valid bits that cycle; buff_res_o.valid forced 0.
  - In WAIT, the pending response is still awaited but discarded (not written). FSM then returns to IDLE.
  - flush_i has priority over a simultaneous write.
- Reset: all valid bits 0, FSM IDLE, latched address 0. lowX_req_o.valid=0. buff_res_o.valid=0. buffer_miss_o equals buff_req_i.valid.
- Reset mid-WAIT abandons the request; a late response is ignored.
- lowX_res_i.valid in IDLE is ignored.

Decomposition:
- Package holds the shared typedefs: gbuff_res_t, icache_req_t, icache_res_t, and the constants XLEN and BLK_SIZE.
- One sub-module, align_bank (parameterized parcel-bank RAM with tag/valid), instantiated twice: even and odd.
- Alignment mux and FSM stay in the top.

Test Plan:
- Cold miss at addr 0x8000_0000:
  - buffer_miss_o=1, next cycle lowX_req_o.addr=0x8000_0000.
  - Return line 0x…_0013_0537 (parcels 0..7).
  - Cycle after the response: buff_res_o.valid=1, blk=0x0013_0537 (parcel1:parcel0).
- Odd-parcel hit at addr 0x8000_0002 on the resident line: same-cycle blk={parcel2,parcel1}, no lowX_req_o.
- Straddle at 0x8000_000E, parcel7=0x0297 (32-bit):
  - request 0x8000_0010.
  - after fill, blk={line1 parcel0, 0x0297}.
- Compressed at p=7 (0x8000_000E, parcel7=0x4501): hit without fetching 0x8000_0010; blk[15:0]=0x4501.
- flush_i during WAIT:
  - the response returns and is not stored.
  - the re-request of the same PC misses again and issues a new lowX_req_o.
- Uncached at 0x1000_0000:
  - served after fill.
  - move to 0x1000_0010, then back to 0x1000_0000: miss again, lowX_req_o.uncached=1.
